// File: rtl/score_bcd_converter.sv
// Iterative shift-add-3 binary-to-BCD converter for the score display.
// Re-converts whenever the sampled score changes; the bcd output is double-buffered.
module score_bcd_converter #(
   parameter int DIGITS = 6,
   parameter int BIN_W  = 20
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [31:0]           score,
   output logic [4*DIGITS-1:0]   bcd,
   output logic                  valid,
   output logic                  busy,
   output logic                  update,
   output logic                  overflow
);

   localparam int               BCD_W     = 4 * DIGITS;
   localparam logic [31:0]      MAX_VAL   = 32'(10 ** DIGITS - 1);
   localparam logic [BIN_W-1:0] MAX_OP    = BIN_W'(MAX_VAL);
   localparam logic [4:0]       LAST_ITER = 5'(BIN_W - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_SHIFT,
      S_DONE
   } state_t;

   state_t             r_state;
   logic [BIN_W-1:0]   r_operand;
   logic [BCD_W-1:0]   r_scratch;
   logic [4:0]         r_count;
   logic [31:0]        r_last_score;
   logic               r_first;
   logic               r_ovf;

   logic [BIN_W-1:0]   w_operand;
   logic               w_ovf;
   logic [BCD_W-1:0]   w_adj;
   logic               w_start;

   // Negative scores display as zero; anything above the display range saturates.
   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      w_operand = score[BIN_W-1:0];
      w_ovf     = 1'b0;
      if (score[31]) begin
         w_operand = '0;
      end else if (score > MAX_VAL) begin
         w_operand = MAX_OP;
         w_ovf     = 1'b1;
      end
   end

   always_comb begin
      w_adj = r_scratch;
      for (int d = 0; d < DIGITS; d++) begin
         if (r_scratch[4*d +: 4] >= 4'd5) begin
            w_adj[4*d +: 4] = r_scratch[4*d +: 4] + 4'd3;
         end
      end
   end

   assign w_start = (score != r_last_score) || r_first;

   // NOTE: sequential state uses non-blocking assignments only, so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state      <= S_IDLE;
         r_operand    <= '0;
         r_scratch    <= '0;
         r_count      <= '0;
         r_last_score <= '0;
         r_first      <= 1'b1;
         r_ovf        <= 1'b0;
         bcd          <= '0;
         valid        <= 1'b0;
         busy         <= 1'b0;
         update       <= 1'b0;
         overflow     <= 1'b0;
      end else begin
         update <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_start) begin
                  r_operand    <= w_operand;
                  r_ovf        <= w_ovf;
                  r_scratch    <= '0;
                  r_count      <= '0;
                  r_last_score <= score;
                  r_first      <= 1'b0;
                  busy         <= 1'b1;
                  r_state      <= S_SHIFT;
               end
            end
            S_SHIFT: begin
               // Bits leaving the top of the scratch are always zero thanks to saturation.
               r_scratch <= {w_adj[BCD_W-2:0], r_operand[BIN_W-1]};
               r_operand <= {r_operand[BIN_W-2:0], 1'b0};
               r_count   <= r_count + 5'd1;
               if (r_count == LAST_ITER) begin
                  r_state <= S_DONE;
               end
            end
            S_DONE: begin
               bcd      <= r_scratch;
               valid    <= 1'b1;
               overflow <= r_ovf;
               update   <= 1'b1;
               busy     <= 1'b0;
               r_state  <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_score_bcd_converter.sv
// Self-checking bench for score_bcd_converter: randomized scores against a
// decimal-arithmetic reference model, plus latency, buffering and reset scenarios.
module tb_score_bcd_converter;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] score;
   logic [23:0] bcd;
   logic        valid, busy, update, overflow;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   score_bcd_converter dut (
      .clk      (clk),
      .reset    (reset),
      .score    (score),
      .bcd      (bcd),
      .valid    (valid),
      .busy     (busy),
      .update   (update),
      .overflow (overflow)
   );

   // Reference: clamp the signed score into 0..999999, then peel off decimal digits.
   function automatic logic [24:0] ref_model(input logic [31:0] s);
      longint      v;
      logic        ovf;
      logic [23:0] r;
      ovf = 1'b0;
      r   = '0;
      if ($signed(s) < 0) v = 0;
      else if (longint'(s) > 999999) begin
         v   = 999999;
         ovf = 1'b1;
      end else v = longint'(s);
      for (int i = 0; i < 6; i++) begin
         r[4*i +: 4] = 4'(v % 10);
         v = v / 10;
      end
      return {ovf, r};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Waits for the update pulse, expecting it on edge exp_edges after the call.
   task automatic collect(input string name, input logic [31:0] s, input int exp_edges);
      logic [24:0] exp;
      logic [23:0] prev;
      int          edges, busy_cnt;
      bit          got, changed;
      exp      = ref_model(s);
      prev     = bcd;
      edges    = 0;
      busy_cnt = 0;
      got      = 0;
      changed  = 0;
      for (int i = 0; i < 60 && !got; i++) begin
         step();
         edges++;
         if (update) got = 1;
         else begin
            if (busy) busy_cnt++;
            if (bcd !== prev) changed = 1;
         end
      end
      checks++;
      if (!got) begin
         failures++;
         $display("FAIL %s_timeout: no update within 60 cycles", name);
         return;
      end
      checks++;
      if (edges !== exp_edges) begin
         failures++;
         $display("FAIL %s_latency: got %0d edges, expected %0d", name, edges, exp_edges);
      end
      checks++;
      if (busy_cnt !== exp_edges - 1) begin
         failures++;
         $display("FAIL %s_busy_len: got %0d, expected %0d", name, busy_cnt, exp_edges - 1);
      end
      checks++;
      if (busy !== 1'b0) begin
         failures++;
         $display("FAIL %s_busy_at_update: got %b, expected 0", name, busy);
      end
      checks++;
      if (changed) begin
         failures++;
         $display("FAIL %s_bcd_stable: bcd changed before update, expected hold at %h", name, prev);
      end
      checks++;
      if (bcd !== exp[23:0]) begin
         failures++;
         $display("FAIL %s_bcd: got %h, expected %h", name, bcd, exp[23:0]);
      end
      checks++;
      if (overflow !== exp[24]) begin
         failures++;
         $display("FAIL %s_overflow: got %b, expected %b", name, overflow, exp[24]);
      end
      checks++;
      if (valid !== 1'b1) begin
         failures++;
         $display("FAIL %s_valid: got %b, expected 1", name, valid);
      end
   endtask

   task automatic check_pulse_end(input string name);
      step();
      checks++;
      if (update !== 1'b0 || busy !== 1'b0) begin
         failures++;
         $display("FAIL %s_pulse_end: update=%b busy=%b, expected 0 0", name, update, busy);
      end
   endtask

   task automatic check_reset_outputs(input string name);
      checks++;
      if (bcd !== 24'h0 || valid !== 1'b0 || busy !== 1'b0 || update !== 1'b0 || overflow !== 1'b0) begin
         failures++;
         $display("FAIL %s: bcd=%h valid=%b busy=%b update=%b overflow=%b, expected all zero",
                  name, bcd, valid, busy, update, overflow);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      score = 32'd0;
      repeat (3) step();
      check_reset_outputs("reset_values");
      reset = 1'b0;
      collect("reset_zero", 32'd0, 22);
      check_pulse_end("reset_zero");
   endtask

   task automatic test_basic();
      score = 32'd1234;
      collect("basic_1234", 32'd1234, 22);
      check_pulse_end("basic_1234");
      repeat (5) step();
      checks++;
      if (busy !== 1'b0 || bcd !== 24'h001234) begin
         failures++;
         $display("FAIL basic_hold: busy=%b bcd=%h, expected 0 001234", busy, bcd);
      end
   endtask

   task automatic test_overflow();
      score = 32'd1_500_000;
      collect("ovf_1500000", 32'd1_500_000, 22);
      check_pulse_end("ovf_1500000");
      score = 32'd20;
      collect("ovf_clear_20", 32'd20, 22);
      check_pulse_end("ovf_clear_20");
   endtask

   task automatic test_negative();
      score = 32'hFFFF_FFFB;
      collect("negative_5", 32'hFFFF_FFFB, 22);
      check_pulse_end("negative_5");
   endtask

   task automatic test_mid_change();
      score = 32'd220;
      repeat (5) step();
      score = 32'd420;
      collect("mid_first_220", 32'd220, 17);
      collect("mid_second_420", 32'd420, 22);
      check_pulse_end("mid_second_420");
   endtask

   task automatic test_random();
      logic [31:0] s;
      for (int i = 0; i < 9; i++) begin
         do begin
            case (i % 3)
               0:       s = $urandom_range(0, 999999);
               1:       s = $urandom;
               default: s = $urandom_range(0, 99);
            endcase
         end while (s == score);
         score = s;
         collect($sformatf("random_%0d", i), s, 22);
         check_pulse_end($sformatf("random_%0d", i));
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] s;
      for (int i = 0; i < 4; i++) begin
         do s = $urandom_range(0, 2_000_000); while (s == score);
         score = s;
         collect($sformatf("b2b_%0d", i), s, 22);
      end
      check_pulse_end("b2b_last");
   endtask

   task automatic test_reset_mid();
      score = 32'd999;
      repeat (10) step();
      reset = 1'b1;
      #1;
      check_reset_outputs("reset_mid_async");
      repeat (2) step();
      reset = 1'b0;
      collect("after_reset_999", 32'd999, 22);
      check_pulse_end("after_reset_999");
   endtask

   initial begin
      test_reset();
      test_basic();
      test_overflow();
      test_negative();
      test_mid_change();
      test_random();
      test_back_to_back();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
